// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: access-size encodings,
// FSM state type, data width and the alignment helper.
package mem_access_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size field is Funct3[1:0]; the sign/zero choice lives in Funct3[2].
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mau_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (funct3[1:0])
            SZ_H:    r = addr_lo[0];
            SZ_W:    r = |addr_lo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational lane steering for the data memory port --
// store replication, byte enables and load extraction with sign/zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] load_word_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] load_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = load_word_i[7:0];
        case (addr_lo_i)
            2'd0: w_byte = load_word_i[7:0];
            2'd1: w_byte = load_word_i[15:8];
            2'd2: w_byte = load_word_i[23:16];
            2'd3: w_byte = load_word_i[31:24];
        endcase
        // Halfword lane follows addr[1] only, so an odd address falls back to its half.
        w_half = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    end

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (funct3_i[1:0])
            SZ_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_H: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    always_comb begin
        load_data_o = load_word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   load_data_o = {24'h000000, w_byte};
            F3_H:    load_data_o = {{16{w_half[15]}}, w_half};
            F3_HU:   load_data_o = {16'h0000, w_half};
            default: load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one data-memory access at a time, stalls the front
// of the pipe until completion and registers MEM/WB. Option: MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              Reg_w_i,
    input  logic              M_to_R_i,
    input  logic              Mem_W_i,
    input  logic              Mem_Rd_i,
    input  logic [2:0]        Funct3_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] Reg2_data_i,
    input  logic [4:0]        RegD_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_ready_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              Stall_o,
    output logic              Reg_w_o,
    output logic              M_to_R_o,
    output logic [DATA_W-1:0] Read_data_o,
    output logic [DATA_W-1:0] ALU_result_o,
    output logic [4:0]        RegD_o,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    output logic              dbg_state_o
);

    // Memory handshake: dmem_req_o is held high with dmem_we/addr/wdata/be stable
    // from the first BUSY cycle until the cycle in which dmem_ready_i=1; that cycle
    // completes the access and dmem_rdata_i is sampled. ready is ignored in IDLE.

    mau_state_e        r_state;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_store_data;
    logic [2:0]        r_funct3;
    logic [4:0]        r_regd;
    logic              r_reg_w;
    logic              r_m_to_r;
    logic              r_is_store;

    logic              r_reg_w_o;
    logic              r_m_to_r_o;
    logic [DATA_W-1:0] r_read_data_o;
    logic [DATA_W-1:0] r_alu_result_o;
    logic [4:0]        r_regd_o;

    logic              w_mem_access;
    logic              w_start;
    logic              w_busy;
    logic [DATA_W-1:0] w_wdata;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_load_data;

    assign w_mem_access = Mem_Rd_i | Mem_W_i;
    assign w_busy       = (r_state == ST_BUSY);

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign_o;

    assign w_misalign = is_misaligned(Funct3_i, ALU_result_i[1:0]);
    assign w_start    = w_mem_access & ~w_misalign;
    assign misalign_o = r_misalign_o;
`else
    assign w_start    = w_mem_access;
`endif

    mem_lane_align u_lane_align (
        .funct3_i     (r_funct3),
        .addr_lo_i    (r_addr[1:0]),
        .store_data_i (r_store_data),
        .load_word_i  (dmem_rdata_i),
        .wdata_o      (w_wdata),
        .be_o         (w_be),
        .load_data_o  (w_load_data)
    );

    // Gated by reset so the upstream stages are released the instant reset asserts.
    assign Stall_o = reset_i &
                     (((r_state == ST_IDLE) & w_start) | (w_busy & ~dmem_ready_i));

    assign dmem_req_o   = w_busy;
    assign dmem_we_o    = w_busy & r_is_store;
    assign dmem_addr_o  = w_busy ? {r_addr[DATA_W-1:2], 2'b00} : '0;
    assign dmem_wdata_o = (w_busy & r_is_store) ? w_wdata : '0;
    assign dmem_be_o    = w_busy ? w_be : 4'b0000;

    assign Reg_w_o      = r_reg_w_o;
    assign M_to_R_o     = r_m_to_r_o;
    assign Read_data_o  = r_read_data_o;
    assign ALU_result_o = r_alu_result_o;
    assign RegD_o       = r_regd_o;
    assign dbg_state_o  = w_busy;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_store_data   <= '0;
            r_funct3       <= 3'b000;
            r_regd         <= 5'd0;
            r_reg_w        <= 1'b0;
            r_m_to_r       <= 1'b0;
            r_is_store     <= 1'b0;
            r_reg_w_o      <= 1'b0;
            r_m_to_r_o     <= 1'b0;
            r_read_data_o  <= '0;
            r_alu_result_o <= '0;
            r_regd_o       <= 5'd0;
`ifdef MISALIGN_TRAP_EN
            r_misalign_o   <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            r_misalign_o <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr       <= ALU_result_i;
                        r_store_data <= Reg2_data_i;
                        r_funct3     <= Funct3_i;
                        r_regd       <= RegD_i;
                        r_reg_w      <= Reg_w_i;
                        r_m_to_r     <= M_to_R_i;
                        // A simultaneous read+write request resolves to a store.
                        r_is_store   <= Mem_W_i;
                        r_reg_w_o    <= 1'b0;
                        r_m_to_r_o   <= 1'b0;
                        r_state      <= ST_BUSY;
`ifdef MISALIGN_TRAP_EN
                    end else if (w_mem_access) begin
                        r_reg_w_o    <= 1'b0;
                        r_m_to_r_o   <= 1'b0;
                        r_misalign_o <= 1'b1;
`endif
                    end else begin
                        r_reg_w_o      <= Reg_w_i;
                        r_m_to_r_o     <= M_to_R_i;
                        r_alu_result_o <= ALU_result_i;
                        r_regd_o       <= RegD_i;
                        r_read_data_o  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready_i) begin
                        r_reg_w_o      <= r_reg_w;
                        r_m_to_r_o     <= r_m_to_r;
                        r_alu_result_o <= r_addr;
                        r_regd_o       <= r_regd;
                        r_read_data_o  <= r_is_store ? '0 : w_load_data;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_reg_w_o  <= 1'b0;
                        r_m_to_r_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk_i  in  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have ports: reset_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Reg_w_i, M_to_R_i, Mem_W_i, Mem_Rd_i  in  1 each  EX/MEM control bits.
REQ-004 SHALL have ports: Funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-005 SHALL have ports: ALU_result_i  in  32  address, or result for non-memory ops; Reg2_data_i  in  32  store data; RegD_i  in  5  destination register.
REQ-006 SHALL have ports: dmem_req_o  out  1; dmem_we_o  out  1; dmem_addr_o  out  32 (word-aligned); dmem_wdata_o  out  32; dmem_be_o  out  4.
REQ-007 SHALL have ports: dmem_ready_i  in  1  memory completion; dmem_rdata_i  in  32  read word, valid when dmem_ready_i=1.
REQ-008 SHALL have ports: Stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-009 SHALL have ports: Reg_w_o, M_to_R_o  out  1; Read_data_o, ALU_result_o  out  32; RegD_o  out  5  registered MEM/WB outputs.
REQ-010 SHALL have port misalign_o  out  1, present only under MISALIGN_TRAP_EN.

Function
REQ-011 SHALL implement FSM states IDLE and BUSY.
REQ-012 In IDLE with Mem_Rd_i=Mem_W_i=0, SHALL copy control, ALU_result_i and RegD_i to MEM/WB outputs at the next edge, with 1-cycle latency and Stall_o=0.
REQ-013 In IDLE with Mem_Rd_i or Mem_W_i set, SHALL drive Stall_o=1 combinationally, latch address, store data, Funct3_i, RegD_i and control, and move to BUSY.
REQ-014 SHALL write a bubble to MEM/WB (Reg_w_o=0, M_to_R_o=0) on that IDLE->BUSY edge.
REQ-015 In BUSY, SHALL hold dmem_req_o=1 and all dmem_* outputs stable until dmem_ready_i=1.
REQ-016 In BUSY, Stall_o SHALL be 1 while dmem_ready_i=0 and 0 in the cycle dmem_ready_i=1.
REQ-017 In BUSY with dmem_ready_i=1, SHALL write the latched access to MEM/WB at that edge and return to IDLE; minimum load/store latency is 2 cycles.
REQ-018 Each BUSY cycle with dmem_ready_i=0 SHALL write a bubble to MEM/WB.
REQ-019 If Mem_Rd_i and Mem_W_i are both set, SHALL treat the access as a store.
REQ-020 On loads, SHALL select the lane by addr[1:0] and sign-extend (B/H) or zero-extend (BU/HU) into Read_data_o; W passes through.
REQ-021 On stores, SHALL replicate data across lanes (byte x4, half x2) and set be: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111.
REQ-022 dmem_addr_o SHALL be {addr[31:2],2'b00}; dmem_we_o=1 only for stores.
REQ-023 dmem_ready_i SHALL be ignored in IDLE.

Reset
REQ-024 Asserting reset_i SHALL immediately force IDLE, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, Stall_o=0, and all MEM/WB outputs 0 (misalign_o=0), including mid-BUSY; the pending access SHALL be dropped.
REQ-025 The first edge after release SHALL be treated as IDLE.

Configuration
REQ-026 With MISALIGN_TRAP_EN defined, a H/HU access with addr[0]=1 or a W access with addr[1:0]!=0 SHALL not enter BUSY and SHALL issue no dmem_req_o.
REQ-027 In that misaligned case, the unit SHALL register misalign_o=1 and Reg_w_o=0 for one cycle, with Stall_o=0.
REQ-028 Without MISALIGN_TRAP_EN, misaligned accesses SHALL proceed using the truncated lane/be math of REQ-020/021, and misalign_o SHALL not exist.

Structure
REQ-029 A shared package SHALL hold the Funct3 size encodings, the FSM state enum and the 32-bit data width constant.
REQ-030 Lane alignment/extension and byte-enable generation SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-031 ALU op, ALU_result_i=0x1234, RegD_i=5, Reg_w_i=1 -> next edge Reg_w_o=1, ALU_result_o=0x1234, RegD_o=5, Stall_o=0 throughout.
REQ-032 LB at addr 0x103 with ready after 3 BUSY cycles and rdata=0x80000000 -> Stall_o=1 for 3 cycles, then Read_data_o=0xFFFFFF80, M_to_R_o=1.
REQ-033 SH at addr 0x202 with Reg2_data_i=0xABCD1234 -> dmem_be_o=1100, dmem_wdata_o=0x12341234, dmem_addr_o=0x200, dmem_we_o=1.
REQ-034 Reset asserted in BUSY with ready=0 -> dmem_req_o=0 and Stall_o=0 immediately; after release, ALU ops pass through normally.
REQ-035 Under MISALIGN_TRAP_EN, LW at addr 0x06 -> no dmem_req_o, misalign_o=1 for one cycle, Reg_w_o=0.
REQ-036 Back-to-back LW, SW, each with ready in first BUSY cycle -> each completes in 2 cycles, no lost or duplicated access.
